// File: rtl/ro_channel_scanner_pkg.sv
// Shared types and sizing helpers for the ring-oscillator channel scanner.
package ro_channel_scanner_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    STORE  = 2'd3
  } state_t;

  // Timer holds at most max(gate, settle)-1.
  function automatic int timer_width(input int gate, input int settle);
    int m;
    m = (gate > settle) ? gate : settle;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ro_edge_sync.sv
// Two-flop synchronizer for an asynchronous oscillator tap plus rising-edge detect.
module ro_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic edge_out
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign edge_out = sync & ~prev;

endmodule

// File: rtl/ro_channel_scanner.sv
// Steps the oscillator mux through four channels, counts edges over a gate
// window, and files each count into a per-channel result with a polled read port.
module ro_channel_scanner
  import ro_channel_scanner_pkg::*;
#(
  parameter int CNT_W         = 16,
  parameter int GATE_CYCLES   = 1024,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ro_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  input  logic [SEL_W-1:0] rd_ch,
  output logic [CNT_W-1:0] rd_data,
  input  logic             rd_ack,
  output logic [NCH-1:0]   done,
  output logic [NCH-1:0]   ovf
);

  localparam int            TW          = timer_width(GATE_CYCLES, SETTLE_CYCLES);
  localparam logic [TW-1:0] GATE_LOAD   = TW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE_CYCLES - 1);

  logic             edge_det;
  state_t           state;
  logic [TW-1:0]    timer;
  logic [CNT_W-1:0] counter;
  logic             sat;
  logic [CNT_W-1:0] result [NCH];

  ro_edge_sync u_edge_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (ro_in),
    .edge_out (edge_det)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      busy    <= 1'b0;
      timer   <= '0;
      counter <= '0;
      sat     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            state <= SETTLE;
            busy  <= 1'b1;
            timer <= SETTLE_LOAD;
          end
        end
        SETTLE: begin
          counter <= '0;
          sat     <= 1'b0;
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (timer == '0) begin
            state <= GATE;
            timer <= GATE_LOAD;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        GATE: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            // The edge on the final gate cycle still counts.
            if (edge_det) begin
              if (&counter) sat <= 1'b1;
              else          counter <= counter + 1'b1;
            end
            if (timer == '0) state <= STORE;
            else             timer <= timer - 1'b1;
          end
        end
        STORE: begin
          sel <= sel + 1'b1;
          if (en) begin
            state <= SETTLE;
            timer <= SETTLE_LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-channel result slot; a store in the same cycle as rd_ack wins.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic             store_hit;
    logic             clr_hit;
    logic [CNT_W-1:0] slot;
    logic             done_bit;
    logic             ovf_bit;

    assign store_hit = (state == STORE) && (sel == SEL_W'(gi));
    assign clr_hit   = rd_ack && (rd_ch == SEL_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot     <= '0;
        done_bit <= 1'b0;
        ovf_bit  <= 1'b0;
      end else if (store_hit) begin
        slot     <= counter;
        done_bit <= 1'b1;
        ovf_bit  <= sat;
      end else if (clr_hit) begin
        done_bit <= 1'b0;
        ovf_bit  <= 1'b0;
      end
    end

    assign result[gi] = slot;
    assign done[gi]   = done_bit;
    assign ovf[gi]    = ovf_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= result[rd_ch];
  end

endmodule

// File: tb/tb_ro_channel_scanner.sv
// Bench for ro_channel_scanner: divide-by-4 oscillator on the main instance,
// divide-by-2 on a 3-bit instance to force saturation.
module tb_ro_channel_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ro_in;
  logic [1:0] sel;
  logic       busy;
  logic [1:0] rd_ch = 2'd0;
  logic [3:0] rd_data;
  logic       rd_ack = 1'b0;
  logic [3:0] done;
  logic [3:0] ovf;

  logic       en2 = 1'b0;
  logic       ro_in2;
  logic [1:0] sel2;
  logic       busy2;
  logic [1:0] rd_ch2 = 2'd0;
  logic [2:0] rd_data2;
  logic       rd_ack2 = 1'b0;
  logic [3:0] done2;
  logic [3:0] ovf2;

  logic [1:0] div = 2'd0;

  int checks = 0;
  int failures = 0;
  int exp_q[$];

  typedef struct {
    logic [1:0] ch;
    logic       ack;
    logic [3:0] exp_data;
    logic [3:0] exp_done;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(negedge clk) div = div + 2'd1;
  assign ro_in  = div[1];
  assign ro_in2 = div[0];

  ro_channel_scanner #(.CNT_W(4), .GATE_CYCLES(16), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ro_in(ro_in), .sel(sel), .busy(busy),
    .rd_ch(rd_ch), .rd_data(rd_data), .rd_ack(rd_ack), .done(done), .ovf(ovf)
  );

  ro_channel_scanner #(.CNT_W(3), .GATE_CYCLES(16), .SETTLE_CYCLES(4)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en2), .ro_in(ro_in2), .sel(sel2), .busy(busy2),
    .rd_ch(rd_ch2), .rd_data(rd_data2), .rd_ack(rd_ack2), .done(done2), .ovf(ovf2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; en2 = 1'b0; rd_ack = 1'b0; rd_ack2 = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Waits for sel to leave 'from'; returns the number of clock edges taken.
  task automatic run_until_sel(input logic [1:0] from, output int n);
    n = 0;
    while (sel == from && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("sel_timeout", 32'(sel), 32'((from + 2'd1) & 2'd3));
  endtask

  // Drives a read (optionally with ack); expectation goes through the scoreboard.
  task automatic do_read(input string name, input logic [1:0] ch, input logic ack,
                         input int exp);
    int e;
    rd_ch = ch;
    rd_ack = ack;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    rd_ack = 1'b0;
    e = exp_q.pop_front();
    chk(name, 32'(rd_data), 32'(e));
  endtask

  initial begin
    int n;
    vecs[0] = '{ch: 2'd0, ack: 1'b0, exp_data: 4'd4, exp_done: 4'b1111};
    vecs[1] = '{ch: 2'd1, ack: 1'b0, exp_data: 4'd4, exp_done: 4'b1111};
    vecs[2] = '{ch: 2'd2, ack: 1'b1, exp_data: 4'd4, exp_done: 4'b1011};
    vecs[3] = '{ch: 2'd3, ack: 1'b0, exp_data: 4'd4, exp_done: 4'b1011};
    vecs[4] = '{ch: 2'd2, ack: 1'b1, exp_data: 4'd4, exp_done: 4'b1011};
    vecs[5] = '{ch: 2'd0, ack: 1'b1, exp_data: 4'd4, exp_done: 4'b1010};

    do_reset();
    chk("rst_sel", 32'(sel), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // Reset mid-GATE
    en = 1'b1;
    repeat (10) tick();
    chk("midrun_busy", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_sel", 32'(sel), 0);
    chk("async_rst_done", 32'(done), 0);
    chk("async_rst_rd_data", 32'(rd_data), 0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_idle", 32'(busy), 0);

    // Single channel
    en = 1'b1;
    run_until_sel(2'd0, n);
    chk("first_period", 32'(n), 22);
    chk("single_sel", 32'(sel), 1);
    en = 1'b0;
    chk("single_done", 32'(done), 32'b0001);
    chk("single_ovf", 32'(ovf), 0);
    do_read("single_rd0", 2'd0, 1'b0, 4);
    tick();
    chk("single_idle", 32'(busy), 0);

    // Full scan with wrap
    do_reset();
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      run_until_sel(2'(k), n);
      chk("scan_sel", 32'(sel), (k + 1) % 4);
      chk("scan_period", 32'(n), (k == 0) ? 22 : 21);
    end
    en = 1'b0;
    tick();
    chk("scan_done", 32'(done), 32'b1111);
    for (int i = 0; i < 6; i++) begin
      do_read($sformatf("scan_rd%0d", i), vecs[i].ch, vecs[i].ack, 32'(vecs[i].exp_data));
      chk($sformatf("scan_done%0d", i), 32'(done), 32'(vecs[i].exp_done));
      chk($sformatf("scan_ovf%0d", i), 32'(ovf), 0);
    end

    // Saturation on the 3-bit instance
    do_reset();
    en2 = 1'b1;
    n = 0;
    while (sel2 == 2'd0 && n < 100) begin
      tick();
      n++;
    end
    en2 = 1'b0;
    chk("sat_period", 32'(n), 22);
    chk("sat_done", 32'(done2), 32'b0001);
    chk("sat_ovf", 32'(ovf2), 32'b0001);
    rd_ch2 = 2'd0;
    tick();
    chk("sat_rd", 32'(rd_data2), 7);
    rd_ack2 = 1'b1;
    tick();
    rd_ack2 = 1'b0;
    chk("sat_ovf_clr", 32'(ovf2), 0);
    chk("sat_done_clr", 32'(done2), 0);
    chk("sat_rd_hold", 32'(rd_data2), 7);

    // Abort on ch1 mid-gate
    do_reset();
    en = 1'b1;
    run_until_sel(2'd0, n);
    repeat (12) tick();
    en = 1'b0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_sel", 32'(sel), 1);
    chk("abort_done", 32'(done), 32'b0001);
    do_read("abort_rd1", 2'd1, 1'b0, 0);
    en = 1'b1;
    run_until_sel(2'd1, n);
    chk("remeasure_period", 32'(n), 22);
    en = 1'b0;
    do_read("remeasure_rd1", 2'd1, 1'b0, 4);
    chk("remeasure_done", 32'(done), 32'b0011);

    // Store and rd_ack to the same channel in the same cycle
    do_reset();
    en = 1'b1;
    repeat (21) tick();
    rd_ch = 2'd0;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    en = 1'b0;
    chk("simul_sel", 32'(sel), 1);
    chk("simul_done", 32'(done), 32'b0001);
    do_read("simul_rd0", 2'd0, 1'b0, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ro_channel_scanner.md
Name: ro_channel_scanner

Overview:
Sequencer and result demultiplexer for the ring-oscillator sensor array. It drives the 2-bit select of the 4:1 oscillator mux and counts rising edges of the muxed oscillator over a fixed gate window. It then steers each count into one of four per-channel result registers and presents them on a polled read port. It is the controlling and receiving end of the oscillator-select mux path.

Parameters:
CNT_W, 16, width of edge counter and result registers
GATE_CYCLES, 1024, clk cycles per measurement gate (>=2)
SETTLE_CYCLES, 8, clk cycles discarded after each sel change (>=3, covers synchronizer flush)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  1 = scan continuously; 0 = stop/abort
ro_in  in  1  muxed oscillator output; asynchronous to clk
sel  out  2  oscillator mux select; current channel
busy  out  1  1 in any state other than IDLE
rd_ch  in  2  channel to read
rd_data  out  CNT_W  result[rd_ch], registered, 1-cycle latency
rd_ack  in  1  1-cycle pulse; clears done[rd_ch]
done  out  4  per-channel fresh-result flags
ovf  out  4  per-channel counter-saturated flags (for the last stored result)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; sel, busy, rd_data, done, ovf, counter, timer and all result registers = 0; synchronizer flops = 0.
- ro_in path: 2-FF synchronizer, then a prev flop. edge = sync & ~prev. At most one edge per clk. Oscillator frequency must be below clk/2 for an accurate count; higher rates alias, and this is not detected.
- FSM states: IDLE, SETTLE, GATE, STORE.
- IDLE: busy=0; sel held. en=1 -> SETTLE, timer=SETTLE_CYCLES-1.
- SETTLE: edges ignored; counter=0. timer==0 -> GATE, timer=GATE_CYCLES-1. Otherwise timer decrements.
- GATE: counter increments on each edge and saturates at all-ones; sat flag set when an increment is attempted at all-ones. Edges on the timer==0 cycle are counted. timer==0 -> STORE.
- STORE (1 cycle):
  - result[sel] <= counter; done[sel] <= 1; ovf[sel] <= sat.
  - sel <= sel+1, wrapping 3 -> 0.
  - en=1 -> SETTLE; en=0 -> IDLE.
- en=0 in SETTLE or GATE: abort. Next state is IDLE; no store; sel unchanged, so the same channel restarts on the next en=1. The counter is discarded.
- en=0 observed in STORE: the store completes, then IDLE.
- Per-channel period: SETTLE_CYCLES + GATE_CYCLES + 1 clk. A full 4-channel scan is 4x that.
- sel changes only on the STORE->next edge. It is glitch-free because it is driven straight from a flop.
- Read port: rd_data <= result[rd_ch] every cycle.
- rd_ack clears done[rd_ch] and ovf[rd_ch]. If a STORE to the same channel happens in the same cycle, the set wins: done=1 and ovf takes the new value.
- rd_ack to a channel whose done=0 has no effect.
- Result registers hold their value until overwritten or reset. An abort leaves them untouched.
- Mid-operation reset returns immediately to the reset values. No partial result is stored.

Decomposition:
- Shared package:
  - NCH=4, SEL_W=2.
  - State enum {IDLE, SETTLE, GATE, STORE}.
  - Timer width function clog2(max(GATE_CYCLES, SETTLE_CYCLES)).
- One natural sub-module, ro_edge_sync: 2-FF synchronizer plus rising-edge detector.
  - Ports: clk, rst_n, async_in, edge_out.
  - Reused for any other async oscillator tap.
- FSM, counter, result array and read port stay in ro_channel_scanner.

Test Plan:
All cases use CNT_W=4, GATE_CYCLES=16, SETTLE_CYCLES=4, with ro_in driven as a clk-synchronous divide-by-4 square wave.
1. Reset mid-GATE: assert en, pulse rst_n low at cycle 10 -> all outputs 0 immediately; done=0000; sel=0; FSM in IDLE.
2. Single channel: en=1 for one channel period (21 clk), then en=0 -> sel goes 0->1; done=0001; rd_ch=0 gives rd_data=4 one cycle later; ovf[0]=0.
3. Full scan with wrap: keep en=1 for 84 clk -> sel visits 0,1,2,3,0; done=1111; all results=4. Then rd_ack on ch2 -> done=1011.
4. Saturation: ro_in at divide-by-2 with CNT_W=3 -> count saturates at 7; ovf[sel]=1; the next rd_ack clears ovf.
5. Abort: drop en at GATE cycle 8 on ch1 -> no store; done[1] unchanged; sel stays 1; re-asserting en measures ch1 again.
6. Simultaneous set/clear: rd_ack on ch0 in the same cycle as STORE to ch0 -> done[0] stays 1 and result is updated.
